// File: rtl/add_sub_nbit_chunked.sv
// ---------------------------------------------------------------------------
// add_sub_nbit_chunked
//   Multi-cycle adder/subtractor. The operation processes CHUNK bits per clock,
//   starting with the least significant chunk. The carry ripples through a
//   register between chunks, so the full-width result is exact. Subtraction
//   is done as A + ~B + ~Cin.
//
// Parameters
//   WIDTH  operand/result width (must be an integer multiple of CHUNK)
//   CHUNK  bits added per clock (>= 1)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   start      request, sampled only in IDLE
//   mode       0 = add, 1 = subtract (sampled with start)
//   in1, in2   operands A and B (sampled with start)
//   Cin        carry-in / borrow-in (sampled with start)
//   busy       high in BUSY and DONE
//   done       one-cycle pulse, result valid
//   Sum        result, held from done until the next accepted start
//   Cout       carry out of MSB (subtract: 1 = no borrow)
//   Ovf        two's-complement signed overflow
//   dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: start is a request that is accepted only while busy is low, and
// it is ignored at all other times. The operands are captured on the accepting
// edge. done pulses exactly once per accepted operation. rst aborts an
// operation, and no done pulse follows.
// ---------------------------------------------------------------------------
module add_sub_nbit_chunked #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;      // already inverted for subtract
  logic               carry;
  logic [CW-1:0]      cnt;

  logic [31:0]        base;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [CHUNK-1:0]   a_ch;
  logic [CHUNK-1:0]   b_ch;
  logic [CHUNK-1:0]   s_ch;
  logic               c_out_ch;
  logic               c_msb;
  logic               last;
  logic [WIDTH-1:0]   chunk_mask;
  logic [WIDTH-1:0]   sum_next;

  assign dbg_state = state;

  // The datapath for one chunk. The bit offset of the active chunk is cnt*CHUNK.
  always_comb begin
    base       = 32'(cnt) * 32'(CHUNK);
    a_sh       = a_q >> base;
    b_sh       = b_q >> base;
    a_ch       = a_sh[CHUNK-1:0];
    b_ch       = b_sh[CHUNK-1:0];
    {c_out_ch, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
    // For the MSB, sum = a ^ b ^ carry_in. This recovers the carry into the MSB,
    // and the result holds for any CHUNK, including CHUNK == 1.
    c_msb      = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ s_ch[CHUNK-1];
    last       = (cnt == CW'(NCHUNK - 1));
    chunk_mask = WIDTH'({CHUNK{1'b1}}) << base;
    sum_next   = (Sum & ~chunk_mask) | ((WIDTH'(s_ch)) << base);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Sum   <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= in1;
            b_q   <= mode ? ~in2 : in2;
            carry <= Cin ^ mode;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          Sum   <= sum_next;
          carry <= c_out_ch;
          if (last) begin
            Cout  <= c_out_ch;
            Ovf   <= c_msb ^ c_out_ch;
            done  <= 1'b1;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_nbit_chunked.sv
// ---------------------------------------------------------------------------
// tb_add_sub_nbit_chunked
//   This bench drives two instances from the same stimulus. Instance 0 uses
//   WIDTH=16, CHUNK=4, and instance 1 uses WIDTH=16, CHUNK=16. An arithmetic
//   reference model predicts busy, done and the result for each instance on
//   every cycle. Directed operations pin both the DUTs and the model to values
//   computed by hand.
// ---------------------------------------------------------------------------
module tb_add_sub_nbit_chunked;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        Cin;

  logic        busy0, done0, cout0, ovf0;
  logic [15:0] sum0;
  logic [1:0]  st0;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] sum1;
  logic [1:0]  st1;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  add_sub_nbit_chunked #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in1(in1), .in2(in2),
    .Cin(Cin), .busy(busy0), .done(done0), .Sum(sum0), .Cout(cout0),
    .Ovf(ovf0), .dbg_state(st0)
  );

  add_sub_nbit_chunked #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .in1(in1), .in2(in2),
    .Cin(Cin), .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1),
    .Ovf(ovf1), .dbg_state(st1)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns {cout, ovf, sum}. The result is computed with ordinary integer
  // arithmetic.
  function automatic logic [17:0] ref_op(input logic m, input logic [15:0] a,
                                         input logic [15:0] b, input logic ci);
    int t;
    int s;
    logic [15:0] r;
    logic co;
    logic ov;
    if (!m) begin
      t  = int'(a) + int'(b) + int'(ci);
      s  = int'($signed(a)) + int'($signed(b)) + int'(ci);
      co = (t >= 65536);
    end else begin
      t  = int'(a) - int'(b) - int'(ci);
      s  = int'($signed(a)) - int'($signed(b)) - int'(ci);
      co = (t >= 0);
    end
    r  = t[15:0];
    ov = (s > 32767) || (s < -32768);
    return {co, ov, r};
  endfunction

  function automatic int nch(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // ---------------- reference model ----------------
  // k = number of edges since the accepting edge (-1 means idle).
  // The result becomes visible NCHUNK edges after acceptance. The unit is
  // idle again one edge later.
  int          k      [2];
  logic [17:0] pend   [2];
  logic [15:0] m_sum  [2];
  logic        m_cout [2];
  logic        m_ovf  [2];
  logic        m_busy [2];
  logic        m_done [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        k[i] <= -1; m_busy[i] <= 1'b0; m_done[i] <= 1'b0;
        m_sum[i] <= '0; m_cout[i] <= 1'b0; m_ovf[i] <= 1'b0;
      end else if (k[i] < 0) begin
        m_done[i] <= 1'b0;
        if (start) begin
          pend[i]   <= ref_op(mode, in1, in2, Cin);
          k[i]      <= 0;
          m_busy[i] <= 1'b1;
        end
      end else if (k[i] + 1 == nch(i)) begin
        k[i]      <= k[i] + 1;
        m_done[i] <= 1'b1;
        m_cout[i] <= pend[i][17];
        m_ovf[i]  <= pend[i][16];
        m_sum[i]  <= pend[i][15:0];
      end else if (k[i] == nch(i)) begin
        k[i] <= -1; m_busy[i] <= 1'b0; m_done[i] <= 1'b0;
      end else begin
        k[i] <= k[i] + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy0", 32'(busy0), 32'(m_busy[0]));
      check("done0", 32'(done0), 32'(m_done[0]));
      if (k[0] < 0 || k[0] == nch(0)) begin
        check("sum0",  32'(sum0),  32'(m_sum[0]));
        check("cout0", 32'(cout0), 32'(m_cout[0]));
        check("ovf0",  32'(ovf0),  32'(m_ovf[0]));
      end
      check("busy1", 32'(busy1), 32'(m_busy[1]));
      check("done1", 32'(done1), 32'(m_done[1]));
      if (k[1] < 0 || k[1] == nch(1)) begin
        check("sum1",  32'(sum1),  32'(m_sum[1]));
        check("cout1", 32'(cout1), 32'(m_cout[1]));
        check("ovf1",  32'(ovf1),  32'(m_ovf[1]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Runs one operation with both units idle. If inject is 1, start pulses with
  // different operands on the second BUSY cycle of instance 0, and both units
  // must ignore it.
  task automatic run_op(input string name, input logic m, input logic [15:0] a,
                        input logic [15:0] b, input logic ci, input int inject,
                        input logic [15:0] es, input logic ec, input logic eo);
    int nb, nd, dc, dc1;
    logic [15:0] s0, s1;
    logic c0, o0, c1, o1;
    nb = 0; nd = 0; dc = -1; dc1 = -1;
    s0 = '0; s1 = '0; c0 = 0; o0 = 0; c1 = 0; o1 = 0;
    @(negedge clk);
    mode = m; in1 = a; in2 = b; Cin = ci; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (inject == 1 && c == 2) begin
        start = 1'b1; in1 = ~a; in2 = 16'h0F0F; mode = ~m; Cin = ~ci;
      end
      if (inject == 1 && c == 3) start = 1'b0;
      if (busy0) nb++;
      if (done0) begin nd++; dc = c; s0 = sum0; c0 = cout0; o0 = ovf0; end
      if (done1 && dc1 < 0) begin dc1 = c; s1 = sum1; c1 = cout1; o1 = ovf1; end
      if (c > 1 && !busy0 && !busy1) break;
    end
    check({name, "_ndone"},   32'(nd),  32'd1);
    check({name, "_latency"}, 32'(dc),  32'd5);
    check({name, "_busycyc"}, 32'(nb),  32'd5);
    check({name, "_sum"},     32'(s0),  32'(es));
    check({name, "_cout"},    32'(c0),  32'(ec));
    check({name, "_ovf"},     32'(o0),  32'(eo));
    check({name, "_lat1"},    32'(dc1), 32'd2);
    check({name, "_sum1"},    32'(s1),  32'(es));
    check({name, "_cout1"},   32'(c1),  32'(ec));
    check({name, "_ovf1"},    32'(o1),  32'(eo));
    check({name, "_model"},   32'({m_cout[0], m_ovf[0], m_sum[0]}), 32'({ec, eo, es}));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; in1 = '0; in2 = '0; Cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_on = 1;
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_sum",  32'(sum0),  32'd0);
    check("rst_state", 32'(st0),  32'd0);
    rst = 1'b0;

    run_op("add_5555", 1'b0, 16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0);
    run_op("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",  1'b0, 16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_neg",  1'b1, 16'h0005, 16'h0007, 1'b0, 0, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",  1'b1, 16'h8000, 16'h0001, 1'b0, 0, 16'h7FFF, 1'b1, 1'b1);
    run_op("add_cin",  1'b0, 16'hAAAA, 16'h5555, 1'b1, 0, 16'h0000, 1'b1, 1'b0);
    run_op("sub_bin",  1'b1, 16'h0010, 16'h0001, 1'b1, 0, 16'h000E, 1'b1, 1'b0);
    run_op("restart",  1'b0, 16'h1234, 16'h4321, 1'b0, 1, 16'h5555, 1'b0, 1'b0);

    // Assert reset on the second BUSY cycle. The operation must be aborted
    // without a done pulse.
    begin
      int nd;
      nd = 0;
      @(negedge clk);
      mode = 1'b0; in1 = 16'hF00F; in2 = 16'h0FF0; Cin = 1'b1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      check("abort_busy",  32'(busy0), 32'd0);
      check("abort_done",  32'(done0), 32'd0);
      check("abort_sum",   32'(sum0),  32'd0);
      check("abort_cout",  32'(cout0), 32'd0);
      check("abort_ovf",   32'(ovf0),  32'd0);
      check("abort_state", 32'(st0),   32'd0);
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #1;
        if (done0) nd++;
      end
      check("abort_nodone", 32'(nd), 32'd0);
    end
    run_op("after_rst", 1'b0, 16'h0001, 16'h0001, 1'b0, 0, 16'h0002, 1'b0, 1'b0);

    // Randomized traffic. start may be asserted at any time, operands change
    // freely, and reset occurs occasionally.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 2) == 0);
      mode  = 1'($urandom_range(0, 1));
      Cin   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       in1 = 16'hFFFF;
        1:       in1 = 16'h7FFF;
        2:       in1 = 16'h8000;
        default: in1 = 16'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0:       in2 = 16'h0000;
        1:       in2 = 16'hFFFF;
        default: in2 = 16'($urandom);
      endcase
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/add_sub_nbit_chunked.md
ADD_SUB_NBIT_CHUNKED -- requirements
Module: add_sub_nbit_chunked

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, CHUNK >= 1; NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 mode  input  1  0 = add, 1 = subtract; sampled with start.
REQ-007 in1  input  WIDTH  operand A; sampled with start.
REQ-008 in2  input  WIDTH  operand B; sampled with start.
REQ-009 Cin  input  1  carry-in (add) / borrow-in (subtract); sampled with start.
REQ-010 busy  output  1  high while an operation is in progress (BUSY or DONE state).
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 Sum  output  WIDTH  result.
REQ-013 Cout  output  1  carry-out of MSB (subtract: 1 = no borrow).
REQ-014 Ovf  output  1  two's-complement signed overflow.

Function
REQ-015 FSM states IDLE, BUSY, DONE; transitions: IDLE->BUSY on start=1; BUSY->DONE at the edge processing chunk NCHUNK-1; DONE->IDLE unconditionally after one cycle.
REQ-016 On acceptance: latch A=in1; B'=in2 (mode=0) or ~in2 (mode=1); carry0 = Cin (mode=0) or ~Cin (mode=1); chunk counter = 0.
REQ-017 Add: Sum = A + B + Cin mod 2^WIDTH; subtract: Sum = A - B - Cin mod 2^WIDTH.
REQ-018 BUSY: each edge computes chunk[cnt] = A_chunk + B'_chunk + carry, LSB chunk first, writes CHUNK bits of Sum, registers chunk carry-out as next carry, cnt increments.
REQ-019 Latency: done=1 in the cycle following the NCHUNK-th edge after the start-sampling edge; NCHUNK=1 gives done one cycle after acceptance.
REQ-020 Cout = carry out of the final chunk; Ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, both updated at the final chunk edge.
REQ-021 start while busy=1 SHALL be ignored (no relatch, no restart); one operation per NCHUNK+2 cycles max.
REQ-022 Sum, Cout, Ovf held stable from done=1 until the next accepted start; intermediate Sum values during BUSY are not valid.
REQ-023 done high for exactly one cycle per accepted operation; busy falls in the cycle after done.
REQ-024 Full-width carry ripple across all chunk boundaries SHALL be exact (no carry lookahead assumptions between chunks).

Reset
REQ-025 rst=1 at a rising edge: state IDLE, counter 0, busy=0, done=0, Sum=0, Cout=0, Ovf=0.
REQ-026 rst mid-operation aborts it: no done pulse; first start after rst release accepted normally.
REQ-027 rst has priority over start in the same cycle.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-028 add 0x1234+0x4321, Cin=0 -> Sum=0x5555, Cout=0, Ovf=0, done 4 edges after start edge, busy high 5 cycles.
REQ-029 add 0xFFFF+0x0001, Cin=0 -> Sum=0x0000, Cout=1, Ovf=0 (carry through all 4 chunks); 0x7FFF+0x0001 -> 0x8000, Cout=0, Ovf=1.
REQ-030 subtract 0x0005-0x0007, Cin=0 -> Sum=0xFFFE, Cout=0, Ovf=0; 0x8000-0x0001 -> 0x7FFF, Cout=1, Ovf=1.
REQ-031 start pulsed with different operands on 2nd BUSY cycle -> ignored; result matches first operands; single done pulse.
REQ-032 rst asserted on 2nd BUSY cycle -> all outputs 0 next cycle, no done; subsequent 0x0001+0x0001 -> Sum=0x0002.
REQ-033 CHUNK=16: 0xAAAA+0x5555, Cin=1 -> Sum=0x0000, Cout=1, Ovf=0, done one cycle after start edge.
